// File: rtl/bird_physics_pkg.sv
// bird_physics_pkg
//   Shared game parameters and types for the bird physics block and the
//   death checker: screen geometry, start height, death band limits, the
//   physics state enum and the height clamp helper.
package bird_physics_pkg;

  localparam int SCREEN_H     = 480;
  localparam int START_HEIGHT = 240;
  localparam int DEAD_TOP     = 10;
  localparam int DEAD_BOTTOM  = 420;

  localparam int HEIGHT_W = 9;
  localparam int VEL_W    = 6;
  // Wide enough that height (0..479) plus any 6-bit velocity cannot overflow.
  localparam int CALC_W   = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLY    = 2'd1,
    ST_FROZEN = 2'd2
  } bird_state_e;

  // Clamp a signed candidate height onto the visible rows [0, SCREEN_H-1].
  function automatic logic [HEIGHT_W-1:0] clamp_height(input logic signed [CALC_W-1:0] h);
    logic signed [CALC_W-1:0] h_max;
    h_max = CALC_W'(SCREEN_H - 1);
    if (h < 0)
      return '0;
    else if (h > h_max)
      return HEIGHT_W'(SCREEN_H - 1);
    else
      return h[HEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Free-running physics tick divider. Counts 0..TICK_DIV-1 and raises tick
//   for the single cycle in which the count sits at TICK_DIV-1 (the wrap
//   cycle). TICK_DIV must be at least 2.
//   Ports:
//     clk   - system clock
//     reset - asynchronous active-low reset, clears the count
//     tick  - one-cycle pulse, once every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/bird_physics.sv
// bird_physics
//   Vertical physics for the bird: IDLE / FLY / FROZEN state machine, flap
//   edge detection with a pending flag, gravity with a fall-speed ceiling,
//   and a clamped height, all updated once per physics tick.
//   Ports:
//     clk      - system clock, all state on the rising edge
//     reset    - asynchronous active-low reset
//     in_game  - player is activated for the game
//     flap     - debounced, clk-synchronous flap button level
//     is_dead  - death flag from the death checker
//     height   - bird top y (0 = screen top, grows downward)
//     velocity - signed vertical velocity, pixels per tick
//     tick     - one-cycle pulse on each physics update
//     flying   - high only while in FLY
//     state    - current state, exposed for debug/checkers
module bird_physics
  import bird_physics_pkg::*;
#(
  parameter int TICK_DIV     = 833333,
  parameter int START_HEIGHT = bird_physics_pkg::START_HEIGHT,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = -8,
  parameter int MAX_FALL     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_game,
  input  logic                       flap,
  input  logic                       is_dead,
  output logic [HEIGHT_W-1:0]        height,
  output logic signed [VEL_W-1:0]    velocity,
  output logic                       tick,
  output logic                       flying,
  output bird_state_e                state
);

  localparam logic [HEIGHT_W-1:0]     START_H = HEIGHT_W'(START_HEIGHT);
  localparam logic signed [VEL_W-1:0] FLAP_V  = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W-1:0] MAX_V   = VEL_W'(MAX_FALL);
  localparam logic signed [CALC_W-1:0] GRAV_C = CALC_W'(GRAVITY);
  localparam logic signed [CALC_W-1:0] MAX_C  = CALC_W'(MAX_FALL);

  bird_state_e state_next;

  logic                     flap_prev;
  logic                     flap_edge;
  logic                     pending;
  logic                     pend_now;
  logic signed [CALC_W-1:0] vel_ext;
  logic signed [CALC_W-1:0] vel_grav;
  logic signed [CALC_W-1:0] h_sum;
  logic signed [VEL_W-1:0]  vel_fall;
  logic signed [VEL_W-1:0]  vel_tick;
  logic [HEIGHT_W-1:0]      h_clamped;

  logic [HEIGHT_W-1:0]      height_next;
  logic signed [VEL_W-1:0]  velocity_next;
  logic                     pending_next;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Physics arithmetic for the current tick. A flap edge landing in the tick
  // cycle itself is folded into pend_now so it is not lost.
  always_comb begin
    flap_edge = flap & ~flap_prev;
    pend_now  = pending | flap_edge;
    vel_ext   = CALC_W'(velocity);
    vel_grav  = vel_ext + GRAV_C;
    vel_fall  = (vel_grav > MAX_C) ? MAX_V : vel_grav[VEL_W-1:0];
    vel_tick  = pend_now ? FLAP_V : vel_fall;
    h_sum     = $signed({{(CALC_W-HEIGHT_W){1'b0}}, height}) + CALC_W'(vel_tick);
    h_clamped = clamp_height(h_sum);
  end

  // Next state and next datapath values.
  always_comb begin
    state_next    = state;
    height_next   = height;
    velocity_next = velocity;
    pending_next  = pending;
    case (state)
      ST_IDLE: begin
        height_next   = START_H;
        velocity_next = '0;
        pending_next  = 1'b0;
        if (in_game && flap_edge) begin
          state_next    = ST_FLY;
          velocity_next = FLAP_V;
          // The launching flap also lifts the bird on the first tick.
          pending_next  = 1'b1;
        end
      end
      ST_FLY: begin
        if (is_dead) begin
          state_next = ST_FROZEN;
        end else if (!in_game) begin
          state_next    = ST_IDLE;
          height_next   = START_H;
          velocity_next = '0;
          pending_next  = 1'b0;
        end else if (tick) begin
          velocity_next = vel_tick;
          height_next   = h_clamped;
          pending_next  = 1'b0;
        end else if (flap_edge) begin
          pending_next = 1'b1;
        end
      end
      ST_FROZEN: begin
        if (!in_game) begin
          state_next    = ST_IDLE;
          height_next   = START_H;
          velocity_next = '0;
          pending_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      height    <= START_H;
      velocity  <= '0;
      pending   <= 1'b0;
      flap_prev <= 1'b0;
    end else begin
      height    <= height_next;
      velocity  <= velocity_next;
      pending   <= pending_next;
      flap_prev <= flap;
    end
  end

  assign flying = (state == ST_FLY);

endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics
//   Directed bench for bird_physics with TICK_DIV=4: reset values, tick
//   cadence, a table of per-tick flight vectors, and hand sequences for
//   pending flaps, clamping, freezing, and asynchronous reset.
module tb_bird_physics;
  import bird_physics_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_game = 1'b0;
  logic               flap = 1'b0;
  logic               is_dead = 1'b0;
  logic [8:0]         height;
  logic signed [5:0]  velocity;
  logic               tick;
  logic               flying;
  bird_state_e        state;

  int passed = 0;
  int total  = 0;
  int unstable = 0;

  typedef struct {
    logic flap;
    int   vel;
    int   h;
  } vec_t;

  vec_t tbl[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  bird_physics #(
    .TICK_DIV (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_game  (in_game),
    .flap     (flap),
    .is_dead  (is_dead),
    .height   (height),
    .velocity (velocity),
    .tick     (tick),
    .flying   (flying),
    .state    (state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance negedge by negedge until tick is high (bounded). Outputs must not
  // move while waiting.
  task automatic wait_tick();
    int n;
    logic [8:0] h0;
    logic signed [5:0] v0;
    n  = 0;
    h0 = height;
    v0 = velocity;
    while (tick !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
      if (height !== h0 || velocity !== v0) unstable++;
    end
    total++;
    if (tick === 1'b1)
      passed++;
    else
      $display("FAIL tick_timeout: got no tick in %0d cycles, expected tick within 4", n);
  endtask

  task automatic add_vec(input logic f, input int v, input int h);
    vec_t e;
    e.flap = f;
    e.vel  = v;
    e.h    = h;
    tbl.push_back(e);
  endtask

  // ---------------- test ----------------
  initial begin
    int bad;
    int ticks;

    // Launch flap is pending, so the first tick applies -8 again.
    add_vec(1'b0, -8, 232); add_vec(1'b0, -7, 225); add_vec(1'b0, -6, 219);
    add_vec(1'b0, -5, 214); add_vec(1'b0, -4, 210); add_vec(1'b0, -3, 207);
    add_vec(1'b0, -2, 205); add_vec(1'b0, -1, 204); add_vec(1'b0,  0, 204);
    // Free fall from velocity 0: +1..+8 then saturated at +8.
    add_vec(1'b0,  1, 205); add_vec(1'b0,  2, 207); add_vec(1'b0,  3, 210);
    add_vec(1'b0,  4, 214); add_vec(1'b0,  5, 219); add_vec(1'b0,  6, 225);
    add_vec(1'b0,  7, 232); add_vec(1'b0,  8, 240); add_vec(1'b0,  8, 248);
    add_vec(1'b0,  8, 256); add_vec(1'b0,  8, 264); add_vec(1'b0,  8, 272);
    // Flap rises in the tick cycle then is held for 10 ticks (40 cycles).
    add_vec(1'b1, -8, 264); add_vec(1'b1, -7, 257); add_vec(1'b1, -6, 251);
    add_vec(1'b1, -5, 246); add_vec(1'b1, -4, 242); add_vec(1'b1, -3, 239);
    add_vec(1'b1, -2, 237); add_vec(1'b1, -1, 236); add_vec(1'b1,  0, 236);
    add_vec(1'b1,  1, 237);
    add_vec(1'b0,  2, 239);

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_height",   height, 240);
    chk("rst_velocity", velocity, 0);
    chk("rst_flying",   flying, 0);
    chk("rst_tick",     tick, 0);
    chk("rst_state",    int'(state), int'(ST_IDLE));

    // Idle for 20 cycles: tick on every 4th cycle, outputs steady.
    reset = 1'b1;
    bad = 0;
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
      if (tick !== (k % 4 == 3)) bad++;
      if (height !== 9'd240 || velocity !== 6'sd0 || flying !== 1'b0) bad++;
    end
    chk("idle_tick_count", ticks, 5);
    chk("idle_errors", bad, 0);

    // Launch on a non-tick cycle.
    in_game = 1'b1;
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    chk("launch_flying",   flying, 1);
    chk("launch_state",    int'(state), int'(ST_FLY));
    chk("launch_velocity", velocity, -8);
    chk("launch_height",   height, 240);

    // Table-driven per-tick vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      wait_tick();
      flap = tbl[i].flap;
      @(negedge clk);
      chk($sformatf("vec%0d_velocity", i), velocity, tbl[i].vel);
      chk($sformatf("vec%0d_height", i),   height,   tbl[i].h);
    end

    // Flap between ticks: outputs unchanged until the next tick applies it.
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    chk("pend_early_velocity", velocity, 2);
    chk("pend_early_height",   height, 239);
    wait_tick();
    @(negedge clk);
    chk("pend_velocity", velocity, -8);
    chk("pend_height",   height, 231);

    // Fall to the bottom clamp.
    for (int i = 0; i < 50; i++) begin
      wait_tick();
      @(negedge clk);
    end
    chk("bottom_clamp_height",   height, 479);
    chk("bottom_clamp_velocity", velocity, 8);

    // Flap on every tick up to the top clamp.
    for (int i = 0; i < 65; i++) begin
      wait_tick();
      flap = 1'b1;
      @(negedge clk);
      flap = 1'b0;
    end
    chk("top_clamp_height",   height, 0);
    chk("top_clamp_velocity", velocity, -8);

    // Death freezes the bird despite flap edges.
    is_dead = 1'b1;
    @(negedge clk);
    chk("dead_state",  int'(state), int'(ST_FROZEN));
    chk("dead_flying", flying, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      flap = (i % 3 == 0);
      @(negedge clk);
      if (height !== 9'd0 || velocity !== -6'sd8 || state !== ST_FROZEN) bad++;
    end
    chk("frozen_hold_errors", bad, 0);
    flap = 1'b0;
    in_game = 1'b0;
    is_dead = 1'b0;
    @(negedge clk);
    chk("leave_frozen_state",    int'(state), int'(ST_IDLE));
    chk("leave_frozen_height",   height, 240);
    chk("leave_frozen_velocity", velocity, 0);

    // Relaunch, then asynchronous reset mid-flight with a flap pending.
    in_game = 1'b1;
    wait_tick();
    @(negedge clk);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    chk("relaunch_flying", flying, 1);
    wait_tick();
    @(negedge clk);
    chk("relaunch_height", height, 232);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_height",   height, 240);
    chk("async_rst_velocity", velocity, 0);
    chk("async_rst_flying",   flying, 0);
    chk("async_rst_tick",     tick, 0);
    chk("async_rst_state",    int'(state), int'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (flying !== 1'b0 || height !== 9'd240) bad++;
    end
    chk("no_fly_without_edge", bad, 0);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    chk("post_rst_flying",   flying, 1);
    chk("post_rst_velocity", velocity, -8);
    wait_tick();
    @(negedge clk);
    chk("post_rst_first_tick_height", height, 232);

    chk("between_tick_stable", unstable, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bird_physics.md
BIRD_PHYSICS -- requirements
Module: bird_physics

Interface
REQ-001 Parameter TICK_DIV, default 833333: clock cycles per physics tick (60 Hz at 50 MHz).
REQ-002 Parameter START_HEIGHT, default 240: height loaded in IDLE.
REQ-003 Parameter GRAVITY, default 1: velocity increment per tick.
REQ-004 Parameter FLAP_VEL, default -8: velocity loaded on flap (signed).
REQ-005 Parameter MAX_FALL, default 8: positive velocity ceiling.
REQ-006 Port clk, input, 1: the single system clock; all state on rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-008 Port in_game, input, 1: player activated for the game.
REQ-009 Port flap, input, 1: debounced, clk-synchronous flap button level.
REQ-010 Port is_dead, input, 1: death flag from the death checker, which consumes height.
REQ-011 Port height, output, 9: bird top y-coordinate. 0 = screen top; increases downward.
REQ-012 Port velocity, output, 6: signed two's-complement vertical velocity, pixels per tick.
REQ-013 Port tick, output, 1: one-cycle pulse on each physics update.
REQ-014 Port flying, output, 1: high only in state FLY.

Function
REQ-015 States SHALL be IDLE, FLY and FROZEN, in a registered state machine.
REQ-016 Transitions:
- IDLE->FLY on in_game=1 with a flap rising edge.
- FLY->FROZEN when is_dead=1.
- FLY->IDLE or FROZEN->IDLE when in_game=0.
- is_dead has priority over in_game within FLY.
REQ-017 The flap rising edge SHALL be detected with a registered previous-flap level. Holding flap high SHALL produce one edge only.
REQ-018 The tick divider SHALL count 0..TICK_DIV-1 and pulse tick on wrap. It SHALL run in every state.
REQ-019 In IDLE: height=START_HEIGHT, velocity=0, flap-pending flag cleared.
REQ-020 In FLY, a flap edge between ticks SHALL set a pending flag. The flag is consumed and cleared at the next tick.
REQ-021 A flap edge in the same cycle as tick SHALL count as pending for that tick.
REQ-022 At each FLY tick, if pending: velocity=FLAP_VEL. Otherwise velocity=min(velocity+GRAVITY, MAX_FALL).
REQ-023 At the same FLY tick, height SHALL become height+new velocity. Use at least 11-bit signed arithmetic, then clamp to [0, 479].
REQ-024 Height and velocity SHALL appear registered on the cycle after tick (latency 1 clock).
REQ-025 The IDLE->FLY transition SHALL load velocity=FLAP_VEL immediately. Height remains START_HEIGHT until the first tick.
REQ-026 In FROZEN, height and velocity SHALL hold, and flap SHALL be ignored.
REQ-027 Outputs SHALL never change between ticks except on a state transition to IDLE or on entry to FLY.

Reset
REQ-028 reset=0 SHALL asynchronously force:
- state=IDLE
- height=START_HEIGHT, velocity=0, tick=0, flying=0
- divider=0, pending=0, previous-flap=0
REQ-029 Reset asserted mid-flight SHALL discard any pending flap. After release, the block SHALL need a fresh flap edge to re-enter FLY.

Structure
REQ-030 SCREEN_H=480, START_HEIGHT, DEAD_TOP=10 and DEAD_BOTTOM=420 SHALL live in the shared game parameter include file. The death checker uses the same file.
REQ-031 The tick divider SHALL be a separate sub-module, tick_gen, parameterised by TICK_DIV. It takes clk and reset and outputs tick.
REQ-032 The implementation SHALL be 120-400 lines of RTL and contain no latches.

Verification (TICK_DIV=4)
REQ-033 Reset, then release; hold flap=0 for 20 cycles.
-> height=240, velocity=0, flying=0, tick every 4th cycle.
REQ-034 in_game=1, flap pulse.
-> FLY, velocity=-8.
-> After ticks: height 232, 225, 219; velocity -7, -6 (from the second tick).
REQ-035 Free fall from velocity 0 for 12 ticks.
-> velocity saturates at +8.
-> Height increments 1, 2, ..., 8, 8, 8, 8, 8.
REQ-036 Flap asserted in the same cycle as tick, and flap held high 40 cycles.
-> FLAP_VEL applied on that tick only.
-> Subsequent ticks apply gravity.
REQ-037 Drive is_dead=1 mid-flight.
-> FROZEN; height and velocity frozen for 50 cycles despite flap edges.
-> in_game=0 returns IDLE with height=240.
REQ-038 reset=0 pulse mid-flight, asynchronous to clk.
-> Outputs return to reset values within the same cycle.
-> No FLY until a new flap edge.
